// File: rtl/spi_slave_gen2.sv
// SPI slave in the clk domain: sclk/cs/mosi are synchronised and sclk edges are
// detected locally. One-entry tx buffer; continuous multi-word frames.
module spi_slave_gen2 #(
    parameter int                DATA_W      = 8,
    parameter int                CPOL        = 0,
    parameter int                CPHA        = 1,
    parameter int                MSB_FIRST   = 1,
    parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(8'hAA),
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int   CW  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic POL = 1'(CPOL);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic [SYNC_STAGES:0]   settle_pipe;
    logic                   armed;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_sh, tx_sh, tx_buf;
    logic              buf_full, rcvd;

    logic              sclk_s, cs_s, mosi_s;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              cs_fall, in_frame, word_done;
    logic [DATA_W-1:0] rx_next, load_word;

    function automatic logic head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tail(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_d == POL) && (sclk_s != POL);
    assign trail_edge  = (sclk_d != POL) && (sclk_s == POL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

    // A frame only starts on a cs fall seen after cs was observed high since reset
    assign cs_fall   = armed && cs_d && !cs_s && (state == IDLE);
    assign in_frame  = (state == ACTIVE) && !cs_s;
    assign rx_next   = (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], mosi_s}
                                        : {mosi_s, rx_sh[DATA_W-1:1]};
    assign word_done = in_frame && sample_edge && (bit_cnt == CW'(DATA_W-1));

    // On a word boundary the just-completed word is the echo source
    assign load_word = buf_full  ? tx_buf  :
                       word_done ? rx_next :
                       rcvd      ? rx_data : IDLE_WORD;

    assign tx_ready = ~buf_full;
    assign busy     = (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= {SYNC_STAGES{POL}};
            cs_sync     <= '1;
            mosi_sync   <= '0;
            sclk_d      <= POL;
            cs_d        <= 1'b1;
            settle_pipe <= '0;
            armed       <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
            if (settle_pipe[SYNC_STAGES] && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            tx_buf    <= '0;
            buf_full  <= 1'b0;
            rcvd      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tx_valid && !buf_full) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    if (cs_fall) begin
                        state <= ACTIVE;
                        if (buf_full)
                            buf_full <= 1'b0;
                        if (CPHA == 0) begin
                            miso  <= head(load_word);
                            tx_sh <= tail(load_word);
                        end else begin
                            tx_sh <= load_word;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state   <= IDLE;
                        miso    <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0)
                            frame_err <= 1'b1;
                    end else begin
                        if (shift_edge) begin
                            miso  <= head(tx_sh);
                            tx_sh <= tail(tx_sh);
                        end
                        if (sample_edge) begin
                            rx_sh <= rx_next;
                            if (word_done) begin
                                bit_cnt  <= '0;
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                rcvd     <= 1'b1;
                                tx_sh    <= load_word;
                                if (buf_full)
                                    buf_full <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_gen2.sv
// Directed bench: default 8-bit slave plus four 16-bit LSB-first slaves,
// one per CPOL/CPHA mode, driven by a shared SPI master task.
module tb_spi_slave_gen2;
    localparam int H = 100;

    logic clk = 1'b0;
    logic rst_n, sclk_b, cs_a, cs_b, mosi;

    logic       miso_a, tx_ready_a, rx_valid_a, frame_err_a, busy_a, tx_valid_a;
    logic [7:0] tx_data_a, rx_data_a;

    logic [3:0]       miso_b, tx_ready_b, rx_valid_b, frame_err_b, busy_b;
    logic [3:0][15:0] rx_data_b;

    int checks = 0, failures = 0;
    int nrxv_a = 0, nfe_a = 0;
    int nrxv_b [4] = '{0, 0, 0, 0};
    logic [31:0] cap_a [2];
    logic [31:0] cap_b [4];
    logic        busy_snap;
    int          r0, f0;

    always #5 clk = ~clk;

    spi_slave_gen2 u_a (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .cs(cs_a), .mosi(mosi),
        .miso(miso_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .frame_err(frame_err_a), .busy(busy_a)
    );

    for (genvar g = 0; g < 4; g++) begin : g_b
        spi_slave_gen2 #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0)) u_b (
            .clk(clk), .rst_n(rst_n), .sclk(sclk_b ^ 1'(g / 2)), .cs(cs_b), .mosi(mosi),
            .miso(miso_b[g]), .tx_data(16'h0000), .tx_valid(1'b0),
            .tx_ready(tx_ready_b[g]), .rx_data(rx_data_b[g]), .rx_valid(rx_valid_b[g]),
            .frame_err(frame_err_b[g]), .busy(busy_b[g])
        );
    end

    always @(posedge clk) begin
        if (rx_valid_a)  nrxv_a <= nrxv_a + 1;
        if (frame_err_a) nfe_a  <= nfe_a + 1;
        for (int i = 0; i < 4; i++)
            if (rx_valid_b[i]) nrxv_b[i] <= nrxv_b[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Master: mosi set, H, leading edge, H, trailing edge, H. CPHA=0 slaves are
    // captured just before the leading edge, CPHA=1 slaves before the trailing edge.
    task automatic xfer(input bit grp_b, input int w, input int nbits, input bit msbf,
                        input logic [31:0] w0, input logic [31:0] w1, input bit keep_cs);
        int wi, j;
        for (int i = 0; i < 2; i++) cap_a[i] = '0;
        for (int i = 0; i < 4; i++) cap_b[i] = '0;
        if (grp_b) cs_b = 1'b0; else cs_a = 1'b0;
        #H;
        busy_snap = grp_b ? busy_b[0] : busy_a;
        for (int k = 0; k < nbits; k++) begin
            wi = k / w;
            j  = msbf ? (w - 1 - (k % w)) : (k % w);
            mosi = (wi == 0) ? w0[j] : w1[j];
            #H;
            if (wi == 0) begin
                cap_b[0][j] = miso_b[0];
                cap_b[2][j] = miso_b[2];
            end
            sclk_b = 1'b1;
            #H;
            cap_a[wi][j] = miso_a;
            if (wi == 0) begin
                cap_b[1][j] = miso_b[1];
                cap_b[3][j] = miso_b[3];
            end
            sclk_b = 1'b0;
            #H;
        end
        if (!keep_cs) begin
            cs_a = 1'b1;
            cs_b = 1'b1;
            #(2 * H);
        end
    endtask

    initial begin
        rst_n = 1'b0; sclk_b = 1'b0; cs_a = 1'b1; cs_b = 1'b1; mosi = 1'b0;
        tx_valid_a = 1'b0; tx_data_a = 8'h00;
        #(H + 3);
        chk("rst_miso", miso_a, 0);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_frame_err", frame_err_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rx_data", rx_data_a, 0);
        rst_n = 1'b1;
        #(2 * H);

        // idle word out, 3C in
        r0 = nrxv_a; f0 = nfe_a;
        xfer(0, 8, 8, 1, 32'h3C, 0, 0);
        chk("f1_miso", cap_a[0], 32'hAA);
        chk("f1_rx_data", rx_data_a, 8'h3C);
        chk("f1_rxv_cnt", nrxv_a - r0, 1);
        chk("f1_ferr_cnt", nfe_a - f0, 0);
        chk("f1_busy", busy_snap, 1);
        chk("f1_idle_miso", miso_a, 0);
        chk("f1_idle_busy", busy_a, 0);

        // echo of previous word
        xfer(0, 8, 8, 1, 32'h00, 0, 0);
        chk("f2_miso", cap_a[0], 32'h3C);
        chk("f2_rx_data", rx_data_a, 8'h00);

        // queued word; second offer while full must be dropped
        tx_data_a = 8'h5A; tx_valid_a = 1'b1;
        #10;
        tx_data_a = 8'h77;
        #30;
        tx_valid_a = 1'b0;
        chk("tx_ready_full", tx_ready_a, 0);
        r0 = nrxv_a;
        xfer(0, 8, 16, 1, 32'h11, 32'h22, 0);
        chk("f3_miso0", cap_a[0], 32'h5A);
        chk("f3_miso1", cap_a[1], 32'h11);
        chk("f3_rx_data", rx_data_a, 8'h22);
        chk("f3_rxv_cnt", nrxv_a - r0, 2);
        chk("f3_tx_ready", tx_ready_a, 1);

        // partial word
        r0 = nrxv_a; f0 = nfe_a;
        xfer(0, 8, 5, 1, 32'hFF, 0, 0);
        chk("p_ferr_cnt", nfe_a - f0, 1);
        chk("p_rxv_cnt", nrxv_a - r0, 0);
        chk("p_rx_data", rx_data_a, 8'h22);
        xfer(0, 8, 8, 1, 32'h81, 0, 0);
        chk("f4_miso", cap_a[0], 32'h22);
        chk("f4_rx_data", rx_data_a, 8'h81);

        // 16-bit LSB-first group, all four modes; slave A sees sclk with cs high
        r0 = nrxv_a;
        xfer(1, 16, 16, 0, 32'hA5C3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b%0d_rx_data", i), rx_data_b[i], 16'hA5C3);
            chk($sformatf("b%0d_miso", i), cap_b[i], 32'h00AA);
            chk($sformatf("b%0d_rxv_cnt", i), nrxv_b[i], 1);
        end
        chk("a_ignores_sclk", nrxv_a - r0, 0);

        // reset in the middle of a frame, cs left low across release
        r0 = nrxv_a; f0 = nfe_a;
        xfer(0, 8, 4, 1, 32'hF0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_miso", miso_a, 0);
        chk("mr_busy", busy_a, 0);
        chk("mr_rx_data", rx_data_a, 0);
        chk("mr_tx_ready", tx_ready_a, 1);
        chk("mr_rx_valid", rx_valid_a, 0);
        chk("mr_frame_err", frame_err_a, 0);
        #H;
        rst_n = 1'b1;
        #(2 * H);
        chk("mr_no_resume", busy_a, 0);
        cs_a = 1'b1;
        #(2 * H);
        chk("mr_no_pulses", (nrxv_a - r0) + (nfe_a - f0), 0);
        xfer(0, 8, 8, 1, 32'h96, 0, 0);
        chk("f5_miso", cap_a[0], 32'hAA);
        chk("f5_rx_data", rx_data_a, 8'h96);
        chk("f5_rxv_cnt", nrxv_a - r0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
